lcd_sync_gen: RTL and testbench
===============================

LCD_SYNC_GEN -- requirements
Module: lcd_sync_gen

Interface
REQ-001 SHALL provide these parameters (name, default, meaning):
- H_ACTIVE, 800, visible pixels per line
- H_FP, 40, horizontal front porch (clocks)
- H_SYNC, 128, horizontal sync width (clocks)
- H_BP, 88, horizontal back porch (clocks)
- V_ACTIVE, 600, visible lines per frame
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 4, vertical sync width (lines)
- V_BP, 23, vertical back porch (lines)
- SYNC_POL, 0, active level of lcd_hs/lcd_vs (0 = active-low)
- DATA_LAT, 2, pixel-source read latency in clocks, range 0..4
- CW, 12, coordinate/counter width
REQ-002 SHALL provide these ports (name, direction, width, meaning):
- clk, in, 1, pixel clock; single clock domain
- rst, in, 1, synchronous active-high reset
- en, in, 1, run request; sampled only at frame boundaries
- pix_data, in, 24, RGB888 from source, valid DATA_LAT clocks after request
- lcd_xpos, out, CW, requested pixel column
- lcd_ypos, out, CW, requested pixel row
- req_valid, out, 1, xpos/ypos request valid
- lcd_hs, out, 1, horizontal sync
- lcd_vs, out, 1, vertical sync
- lcd_de, out, 1, display enable
- lcd_rgb, out, 24, pixel data to panel
- frame_start, out, 1, one-clock pulse with first displayed pixel
- running, out, 1, generator active

Function
REQ-003 SHALL elaborate-fail if CW cannot hold H_TOTAL-1 or V_TOTAL-1, or if DATA_LAT > 4; H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP, V_TOTAL likewise.
REQ-004 SHALL keep h counter 0..H_TOTAL-1, wrapping to 0; v counter increments on h wrap and wraps at V_TOTAL-1.
REQ-005 SHALL order each line and frame as active, front porch, sync, back porch, starting at count 0.
REQ-006 SHALL, while running, drive req_valid=1 with lcd_xpos=h, lcd_ypos=v when h<H_ACTIVE and v<V_ACTIVE; else req_valid=0 and xpos/ypos=0.
REQ-007 SHALL assert internal hs when h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vs when v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), whole lines.
REQ-008 SHALL delay de/hs/vs/frame-start through a DATA_LAT+1 stage register pipeline, so outputs for counter state at cycle t appear at t+DATA_LAT+1.
REQ-009 SHALL register pix_data into lcd_rgb at cycle t+DATA_LAT when delayed de is high; lcd_rgb=0 whenever lcd_de=0.
REQ-010 SHALL drive lcd_hs/lcd_vs at SYNC_POL when asserted, ~SYNC_POL otherwise.
REQ-011 SHALL pulse frame_start for exactly one clock, coincident with lcd_de for pixel (0,0).
REQ-012 SHALL state machine IDLE/RUN: IDLE & en=1 -> RUN next clock with h=v=0; RUN & en=0 at last frame clock (h=H_TOTAL-1, v=V_TOTAL-1) -> IDLE; en changes mid-frame ignored.
REQ-013 SHALL hold counters at 0 and req_valid=0 in IDLE; the output pipeline drains normally, then outputs are idle (de=0, sync inactive, rgb=0).
REQ-014 SHALL drive running=1 exactly in RUN.

Reset
REQ-015 SHALL on rst: state IDLE, counters 0, pipeline cleared, running=0, req_valid=0, xpos=ypos=0, lcd_de=0, lcd_rgb=0, frame_start=0, lcd_hs=lcd_vs=~SYNC_POL, all effective the next clock, including mid-frame.

Verification (H 4/1/2/1, V 3/1/1/1, DATA_LAT=2: 8 clocks/line, 48/frame)
REQ-016 SHALL cover: rst released, en=1 at cycle 0 -> running=1 and req (0,0) at cycle 1; lcd_de and frame_start rise at cycle 4; 4 de clocks per line.
REQ-017 SHALL cover: source returns {y,x} pattern with 2-clock pipe -> lcd_rgb matches requested pixel on every de clock, 0 otherwise.
REQ-018 SHALL cover: sync timing -> lcd_hs low exactly 2 clocks, starting 5 clocks after de rise; lcd_vs low exactly 8 clocks during line 4.
REQ-019 SHALL cover: en dropped mid-frame -> frame completes all 48 clocks, running falls, pipeline drains to idle; en re-asserted -> restart at (0,0).
REQ-020 SHALL cover: rst pulsed mid-frame -> next clock de=0, hs=vs=1, rgb=0, running=0; DATA_LAT=0 build -> lcd_de lags req_valid by 1 clock.

Source files
------------

// File: rtl/lcd_sync_gen.sv
// LCD timing generator: h/v counters, pixel requests and a latency-matched
// sync/DE pipeline so panel outputs line up with the returned pixel data.
module lcd_sync_gen #(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 40,
    parameter int H_SYNC   = 128,
    parameter int H_BP     = 88,
    parameter int V_ACTIVE = 600,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 4,
    parameter int V_BP     = 23,
    parameter bit SYNC_POL = 1'b0,
    parameter int DATA_LAT = 2,
    parameter int CW       = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [23:0]   pix_data,
    output logic [CW-1:0] lcd_xpos,
    output logic [CW-1:0] lcd_ypos,
    output logic          req_valid,
    output logic          lcd_hs,
    output logic          lcd_vs,
    output logic          lcd_de,
    output logic [23:0]   lcd_rgb,
    output logic          frame_start,
    output logic          running
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL - 1 >= 2 ** CW || V_TOTAL - 1 >= 2 ** CW) begin : g_cw_err
        $error("lcd_sync_gen: CW too narrow for H_TOTAL/V_TOTAL");
    end
    if (DATA_LAT < 0 || DATA_LAT > 4) begin : g_lat_err
        $error("lcd_sync_gen: DATA_LAT must be 0..4");
    end

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_A_LAST = CW'(H_ACTIVE - 1);
    localparam logic [CW-1:0] V_A_LAST = CW'(V_ACTIVE - 1);
    localparam logic [CW-1:0] HS_FIRST = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_LAST  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] VS_FIRST = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_LAST  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_h;
    logic [CW-1:0]   r_v;
    logic [DATA_LAT:0] r_de_p;
    logic [DATA_LAT:0] r_hs_p;
    logic [DATA_LAT:0] r_vs_p;
    logic [DATA_LAT:0] r_fs_p;
    logic [23:0]     r_rgb;

    logic            w_run;
    logic            w_de;
    logic            w_hs;
    logic            w_vs;
    logic            w_fs;
    logic [DATA_LAT+1:0] w_de_all;
    logic [DATA_LAT+1:0] w_hs_all;
    logic [DATA_LAT+1:0] w_vs_all;
    logic [DATA_LAT+1:0] w_fs_all;

    assign w_run = (r_state == S_RUN);
    assign w_de  = w_run && (r_h <= H_A_LAST) && (r_v <= V_A_LAST);
    assign w_hs  = w_run && (r_h >= HS_FIRST) && (r_h <= HS_LAST);
    assign w_vs  = w_run && (r_v >= VS_FIRST) && (r_v <= VS_LAST);
    assign w_fs  = w_run && (r_h == '0) && (r_v == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_h     <= '0;
            r_v     <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_h <= '0;
                    r_v <= '0;
                    if (en) r_state <= S_RUN;
                end
                S_RUN: begin
                    if (r_h == H_LAST) begin
                        r_h <= '0;
                        if (r_v == V_LAST) begin
                            r_v <= '0;
                            // en is only honoured at the frame boundary
                            if (!en) r_state <= S_IDLE;
                        end else begin
                            r_v <= r_v + CW'(1);
                        end
                    end else begin
                        r_h <= r_h + CW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Tap [k] holds the counter-state flag from k clocks ago
    assign w_de_all = {r_de_p, w_de};
    assign w_hs_all = {r_hs_p, w_hs};
    assign w_vs_all = {r_vs_p, w_vs};
    assign w_fs_all = {r_fs_p, w_fs};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_de_p <= '0;
            r_hs_p <= '0;
            r_vs_p <= '0;
            r_fs_p <= '0;
            r_rgb  <= '0;
        end else begin
            r_de_p <= w_de_all[DATA_LAT:0];
            r_hs_p <= w_hs_all[DATA_LAT:0];
            r_vs_p <= w_vs_all[DATA_LAT:0];
            r_fs_p <= w_fs_all[DATA_LAT:0];
            r_rgb  <= w_de_all[DATA_LAT] ? pix_data : 24'd0;
        end
    end

    assign req_valid   = w_de;
    assign lcd_xpos    = w_de ? r_h : '0;
    assign lcd_ypos    = w_de ? r_v : '0;
    assign running     = w_run;
    assign lcd_de      = w_de_all[DATA_LAT+1];
    assign frame_start = w_fs_all[DATA_LAT+1];
    assign lcd_hs      = w_hs_all[DATA_LAT+1] ? SYNC_POL : ~SYNC_POL;
    assign lcd_vs      = w_vs_all[DATA_LAT+1] ? SYNC_POL : ~SYNC_POL;
    assign lcd_rgb     = r_rgb;

endmodule

// File: tb/tb_lcd_sync_gen.sv
// Directed bench for lcd_sync_gen on a tiny 8x6 raster,
// with a DATA_LAT=2 instance and a DATA_LAT=0 instance.
module tb_lcd_sync_gen;

    localparam int CW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [23:0]   pix_data;

    logic [CW-1:0] lcd_xpos, lcd_ypos;
    logic          req_valid, lcd_hs, lcd_vs, lcd_de;
    logic [23:0]   lcd_rgb;
    logic          frame_start, running;

    logic [CW-1:0] xpos_0, ypos_0;
    logic          req_valid_0, hs_0, vs_0, de_0;
    logic [23:0]   rgb_0;
    logic          fs_0, running_0;

    always #5 clk = ~clk;

    lcd_sync_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(1'b0), .DATA_LAT(2), .CW(CW)
    ) u_dut (
        .clk(clk), .rst(rst), .en(en), .pix_data(pix_data),
        .lcd_xpos(lcd_xpos), .lcd_ypos(lcd_ypos),
        .req_valid(req_valid), .lcd_hs(lcd_hs), .lcd_vs(lcd_vs),
        .lcd_de(lcd_de), .lcd_rgb(lcd_rgb),
        .frame_start(frame_start), .running(running)
    );

    lcd_sync_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(1'b0), .DATA_LAT(0), .CW(CW)
    ) u_dut0 (
        .clk(clk), .rst(rst), .en(en), .pix_data(pix_data),
        .lcd_xpos(xpos_0), .lcd_ypos(ypos_0),
        .req_valid(req_valid_0), .lcd_hs(hs_0), .lcd_vs(vs_0),
        .lcd_de(de_0), .lcd_rgb(rgb_0),
        .frame_start(fs_0), .running(running_0)
    );

    // Pixel source with a two-clock read latency returning {y,x}
    logic [23:0] r_p1, r_p2;
    always @(posedge clk) begin
        r_p1 <= req_valid ? {lcd_ypos, lcd_xpos} : 24'hA5A5A5;
        r_p2 <= r_p1;
    end
    assign pix_data = r_p2;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s cyc %0d: got %0h want %0h",
                     tag, cyc, obs, exp);
        end
    endtask

    // Expected counter state: frames run from cycle 1 to 96 and from 111 on
    function automatic void st(input int c, output bit run,
                               output int h, output int v);
        int k;
        run = 1'b0;
        k   = 0;
        if (c >= 1 && c <= 96) begin
            run = 1'b1;
            k   = c - 1;
        end else if (c >= 111) begin
            run = 1'b1;
            k   = c - 111;
        end
        h = k % 8;
        v = (k / 8) % 6;
    endfunction

    bit r, ro, r1;
    int h, v, ho, vo, h1, v1;
    bit rv, de, hsa, vsa, fs, de1;
    int n_de, n_de_l0, n_hs_low, n_vs_low;

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        n_de = 0; n_de_l0 = 0; n_hs_low = 0; n_vs_low = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_running", 32'(running), 32'd0);
        chk("rst_req", 32'(req_valid), 32'd0);
        chk("rst_xpos", 32'(lcd_xpos), 32'd0);
        chk("rst_de", 32'(lcd_de), 32'd0);
        chk("rst_hs", 32'(lcd_hs), 32'd1);
        chk("rst_vs", 32'(lcd_vs), 32'd1);
        chk("rst_rgb", 32'(lcd_rgb), 32'd0);
        chk("rst_fs", 32'(frame_start), 32'd0);

        rst = 1'b0;
        en  = 1'b1;
        for (int c = 1; c <= 129; c++) begin
            @(posedge clk);
            #1;
            cyc = c;
            st(c, r, h, v);
            rv = r && h < 4 && v < 3;
            chk("running", 32'(running), 32'(r));
            chk("req_valid", 32'(req_valid), 32'(rv));
            chk("xpos", 32'(lcd_xpos), rv ? 32'(h) : 32'd0);
            chk("ypos", 32'(lcd_ypos), rv ? 32'(v) : 32'd0);

            st(c - 3, ro, ho, vo);
            de  = ro && ho < 4 && vo < 3;
            hsa = ro && (ho == 5 || ho == 6);
            vsa = ro && vo == 4;
            fs  = ro && ho == 0 && vo == 0;
            chk("de", 32'(lcd_de), 32'(de));
            chk("hs", 32'(lcd_hs), 32'(!hsa));
            chk("vs", 32'(lcd_vs), 32'(!vsa));
            chk("frame_start", 32'(frame_start), 32'(fs));
            chk("rgb", 32'(lcd_rgb),
                de ? 32'((vo << 12) | ho) : 32'd0);

            st(c - 1, r1, h1, v1);
            de1 = r1 && h1 < 4 && v1 < 3;
            chk("req_valid_lat0", 32'(req_valid_0), 32'(rv));
            chk("de_lat0", 32'(de_0), 32'(de1));

            if (c >= 4 && c <= 51) begin
                n_de     += int'(lcd_de);
                n_hs_low += int'(!lcd_hs);
                n_vs_low += int'(!lcd_vs);
                if (c <= 11) n_de_l0 += int'(lcd_de);
            end
            if (c == 60) en = 1'b0;
            if (c == 110) en = 1'b1;
        end
        chk("de_line0_count", 32'(n_de_l0), 32'd4);
        chk("de_frame_count", 32'(n_de), 32'd12);
        chk("hs_low_count", 32'(n_hs_low), 32'd12);
        chk("vs_low_count", 32'(n_vs_low), 32'd8);

        // Reset mid-frame, one clock before a displayed pixel
        rst = 1'b1;
        @(posedge clk);
        #1;
        cyc = 130;
        chk("mrst_de", 32'(lcd_de), 32'd0);
        chk("mrst_hs", 32'(lcd_hs), 32'd1);
        chk("mrst_vs", 32'(lcd_vs), 32'd1);
        chk("mrst_rgb", 32'(lcd_rgb), 32'd0);
        chk("mrst_running", 32'(running), 32'd0);
        chk("mrst_req", 32'(req_valid), 32'd0);
        chk("mrst_fs", 32'(frame_start), 32'd0);
        chk("mrst_de_lat0", 32'(de_0), 32'd0);

        rst = 1'b0;
        en  = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        cyc = 134;
        chk("idle_running", 32'(running), 32'd0);
        chk("idle_de", 32'(lcd_de), 32'd0);
        chk("idle_hs", 32'(lcd_hs), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
